// File: rtl/luhn_pkg.sv
// Shared Luhn definitions: frame lengths, FSM encoding and digit weighting.
// Used by both the check-digit generator and the validator side.
package luhn_pkg;

  localparam int CARD_LEN    = 16;
  localparam int PAYLOAD_LEN = 15;

  typedef enum logic [1:0] {
    COLLECT,
    CALC,
    SEND
  } state_t;

  // Even card indices are doubled and folded back into a single digit.
  function automatic logic [3:0] luhn_weight_f(
    input logic [3:0] d,
    input logic       odd
  );
    logic [4:0] dbl;
    dbl = {d, 1'b0};
    if (odd) return d;
    if (dbl > 5'd9) return 4'(dbl - 5'd9);
    return dbl[3:0];
  endfunction

endpackage

// File: rtl/luhn_weight.sv
// Combinational Luhn weighting of one digit given its index parity.
// odd=1 passes the digit through, odd=0 doubles and folds it.
module luhn_weight
  import luhn_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       odd,
  output logic [3:0] weighted
);

  assign weighted = luhn_weight_f(digit, odd);

endmodule

// File: rtl/luhn_check_gen.sv
// Collects a 15-digit card payload and streams it back with a Luhn check digit.
// Frames containing a non-BCD digit are dropped and flagged on bad_digit.
module luhn_check_gen
  import luhn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_digit,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_last,
  input  logic       out_ready,
  output logic       bad_digit
);

  localparam logic [3:0] LAST_IN  = 4'(PAYLOAD_LEN - 1);
  localparam logic [3:0] LAST_OUT = 4'(CARD_LEN - 1);

  state_t     state_q, state_d;
  logic [3:0] in_idx_q;
  logic [3:0] out_idx_q;
  logic [3:0] sum_q;
  logic [3:0] chk_q;
  logic       err_q;
  logic [3:0] buf_q [PAYLOAD_LEN];

  logic       in_fire;
  logic       out_fire;
  logic [3:0] weighted;
  logic [4:0] acc;
  logic [3:0] sum_d;
  logic [3:0] chk_d;
  logic [3:0] card_digit;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  luhn_weight u_weight (
    .digit    (in_digit),
    .odd      (in_idx_q[0]),
    .weighted (weighted)
  );

  // Keep the sum in 0..9 even when a bad digit yields a weight above 9.
  assign acc = {1'b0, sum_q} + {1'b0, weighted};

  always_comb begin
    sum_d = acc[3:0];
    if (acc >= 5'd20)
      sum_d = 4'(acc - 5'd20);
    else if (acc >= 5'd10)
      sum_d = 4'(acc - 5'd10);
  end

  assign chk_d = (sum_q == 4'd0) ? 4'd0 : 4'd10 - sum_q;

  assign card_digit = (out_idx_q == LAST_OUT) ? chk_q : buf_q[out_idx_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_digit = 4'd0;
    bad_digit = 1'b0;
    unique case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && in_idx_q == LAST_IN)
          state_d = CALC;
      end
      CALC: begin
        bad_digit = err_q;
        state_d   = err_q ? COLLECT : SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_digit = card_digit;
        out_last  = (out_idx_q == LAST_OUT);
        if (out_ready && out_idx_q == LAST_OUT)
          state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_idx_q  <= 4'd0;
      out_idx_q <= 4'd0;
      sum_q     <= 4'd0;
      chk_q     <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      if (in_fire) begin
        in_idx_q <= in_idx_q + 4'd1;
        sum_q    <= sum_d;
        if (in_digit > 4'd9)
          err_q <= 1'b1;
      end
      if (state_q == CALC) begin
        chk_q <= chk_d;
        if (err_q) begin
          in_idx_q  <= 4'd0;
          out_idx_q <= 4'd0;
          sum_q     <= 4'd0;
          err_q     <= 1'b0;
        end
      end
      if (out_fire) begin
        if (out_idx_q == LAST_OUT) begin
          in_idx_q  <= 4'd0;
          out_idx_q <= 4'd0;
          sum_q     <= 4'd0;
          err_q     <= 1'b0;
        end else begin
          out_idx_q <= out_idx_q + 4'd1;
        end
      end
    end
  end

  // Payload storage is always rewritten before it is read back.
  always_ff @(posedge clk) begin
    if (in_fire && in_idx_q <= LAST_IN)
      buf_q[in_idx_q] <= in_digit;
  end

endmodule
